// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction fetch path and its queues.
package fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    END   = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

  // Redirect targets are forced onto a word boundary; low bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-side bus: instruction memory port, redirect input and decode handshake.
interface fetch_controller_if #(
  parameter int IFQ_DEPTH = 4
);
  import fetch_pkg::*;

  localparam int OCC_W = $clog2(IFQ_DEPTH + 1);

  logic [XLEN-1:0]   imem_pc;
  logic [INST_W-1:0] imem_inst;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              deq_valid;
  logic              deq_ready;
  logic [XLEN-1:0]   deq_pc;
  logic [INST_W-1:0] deq_inst;
  logic [OCC_W-1:0]  occupancy;
  logic              halted;

  modport master (
    output imem_pc,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output deq_valid,
    input  deq_ready,
    output deq_pc,
    output deq_inst,
    output occupancy,
    output halted
  );

  modport slave (
    input  imem_pc,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  deq_valid,
    output deq_ready,
    input  deq_pc,
    input  deq_inst,
    input  occupancy,
    input  halted
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst} entries; flush empties it and beats a same-cycle push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  ifq_entry_t       push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output ifq_entry_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  ifq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees a slot in the same cycle, so a full queue may still accept.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Storage is not reset, so an empty queue presents zeros rather than stale data.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch PC owner: issues one word read per cycle into a small queue toward decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int              MEM_BYTES = 1024,
  parameter int              IFQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input logic                clk,
  input logic                reset,
  fetch_controller_if.master bus
);

  localparam int              CNT_W   = $clog2(IFQ_DEPTH + 1);
  localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_inc;
  logic [XLEN-1:0]  redirect_target;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  ifq_entry_t       push_entry;
  ifq_entry_t       head;
  logic [CNT_W-1:0] count;

  assign pop             = !q_empty && bus.deq_ready;
  assign push            = (state_q == FETCH) && !bus.redirect_valid && (!q_full || pop);
  assign pc_inc          = pc_q + PC_INC;
  assign redirect_target = align_pc(bus.redirect_pc);
  assign push_entry      = '{pc: pc_q, inst: bus.imem_inst};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redirect_valid) begin
      pc_d    = redirect_target;
      state_d = (redirect_target <= LAST_PC) ? FETCH : END;
    end else if (state_q == FETCH) begin
      if (push) begin
        pc_d = pc_inc;
      end
      // Stop once the next fetch would fall off the end of instruction memory.
      if ((pc_q > LAST_PC) || (push && (pc_inc > LAST_PC))) begin
        state_d = END;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (IFQ_DEPTH)
  ) u_ifq (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect_valid),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (count)
  );

  assign bus.imem_pc   = pc_q;
  assign bus.deq_valid = !q_empty;
  assign bus.deq_pc    = head.pc;
  assign bus.deq_inst  = head.inst;
  assign bus.occupancy = count;
  assign bus.halted    = (state_q == END) && q_empty;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomised bench for fetch_controller with a stream-level scoreboard on the decode side.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int          MEM_BYTES = 1024;
  localparam int          IFQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] LAST_PC   = 32'd1020;
  localparam logic [31:0] DIV_INST  = 32'h024443B3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_controller_if #(.IFQ_DEPTH(IFQ_DEPTH)) bus ();

  fetch_controller #(
    .MEM_BYTES (MEM_BYTES),
    .IFQ_DEPTH (IFQ_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  mem_bytes [MEM_BYTES];
  ifq_entry_t  exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        started  = 1'b0;
  logic        pend_load = 1'b0;
  logic [31:0] pend_target = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [9:0] a;
    if (addr > LAST_PC) return 32'h0;
    a = addr[9:0];
    return {mem_bytes[a], mem_bytes[a + 10'd1], mem_bytes[a + 10'd2], mem_bytes[a + 10'd3]};
  endfunction

  assign bus.imem_inst = word_at(bus.imem_pc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // After a redirect or reset, decode must see every aligned word from the target to the end of memory.
  task automatic load_stream(input logic [31:0] target);
    logic [31:0] a;
    exp_q.delete();
    a = {target[31:2], 2'b00};
    while (a <= LAST_PC) begin
      exp_q.push_back('{pc: a, inst: word_at(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    reset = 1'b0;
    if (pend_load) begin
      load_stream(pend_target);
      pend_load = 1'b0;
      started = 1'b1;
    end
  endtask

  task automatic issue_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = target;
    pend_load = 1'b1;
    pend_target = target;
  endtask

  task automatic issue_reset();
    reset = 1'b1;
    pend_load = 1'b1;
    pend_target = RESET_PC;
  endtask

  initial begin : monitor
    logic        hold_prev;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    int          idle;
    ifq_entry_t  e;
    hold_prev = 1'b0;
    hold_pc = '0;
    hold_inst = '0;
    idle = 0;
    forever begin
      @(negedge clk);
      if (reset || !started) begin
        hold_prev = 1'b0;
        idle = 0;
      end else begin
        check("halted", 32'(bus.halted), 32'(exp_q.size() == 0));
        check("occ_vs_valid", 32'(bus.deq_valid), 32'(bus.occupancy != 3'd0));
        check("occ_bound", 32'(bus.occupancy > 3'd4), 32'd0);
        if (hold_prev) begin
          check("hold_valid", 32'(bus.deq_valid), 32'd1);
          check("hold_pc", bus.deq_pc, hold_pc);
          check("hold_inst", bus.deq_inst, hold_inst);
        end
        if (bus.redirect_valid || bus.deq_valid || exp_q.size() == 0) idle = 0;
        else idle++;
        check("stall_bound", 32'(idle > 2), 32'd0);
        if (bus.deq_valid && bus.deq_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_deq: got pc=%0h inst=%0h, expected no entry", bus.deq_pc, bus.deq_inst);
          end else begin
            e = exp_q.pop_front();
            $display("deq pc=%08h inst=%08h", bus.deq_pc, bus.deq_inst);
            check("deq_pc", bus.deq_pc, e.pc);
            check("deq_inst", bus.deq_inst, e.inst);
          end
        end
        hold_prev = bus.deq_valid && !bus.deq_ready && !bus.redirect_valid;
        hold_pc = bus.deq_pc;
        hold_inst = bus.deq_inst;
      end
    end
  end

  initial begin : stimulus
    logic [31:0] t;
    int          r;
    for (int i = 0; i < MEM_BYTES; i++) mem_bytes[i] = 8'($urandom);
    for (int w = 0; w < 4; w++) begin
      mem_bytes[4*w]     = DIV_INST[31:24];
      mem_bytes[4*w + 1] = DIV_INST[23:16];
      mem_bytes[4*w + 2] = DIV_INST[15:8];
      mem_bytes[4*w + 3] = DIV_INST[7:0];
    end
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.deq_ready = 1'b0;
    reset = 1'b0;

    // Reset values, first-fetch latency, fill to full and hold.
    issue_reset();
    tick();
    check("rst_imem_pc", bus.imem_pc, RESET_PC);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    check("rst_valid", 32'(bus.deq_valid), 32'd0);
    check("rst_deq_pc", bus.deq_pc, 32'd0);
    check("rst_deq_inst", bus.deq_inst, 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    tick();
    check("t1_valid", 32'(bus.deq_valid), 32'd1);
    check("t1_deq_pc", bus.deq_pc, 32'd0);
    check("t1_deq_inst", bus.deq_inst, DIV_INST);
    repeat (3) tick();
    check("t1_full_occ", 32'(bus.occupancy), 32'd4);
    check("t1_full_pc", bus.imem_pc, 32'd16);
    repeat (2) tick();
    check("t1_hold_occ", 32'(bus.occupancy), 32'd4);
    check("t1_hold_pc", bus.imem_pc, 32'd16);

    // Full queue drained while fetching: occupancy stays at 4.
    bus.deq_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      check("t2_occ", 32'(bus.occupancy), 32'd4);
      check("t2_imem_pc", bus.imem_pc, 32'(16 + 4*k));
      check("t2_deq_pc", bus.deq_pc, 32'(4*k));
    end

    // Misaligned redirect flushes PCs 8..20.
    bus.deq_ready = 1'b0;
    issue_redirect(32'd27);
    tick();
    check("t3_occ", 32'(bus.occupancy), 32'd0);
    check("t3_imem_pc", bus.imem_pc, 32'd24);
    check("t3_valid0", 32'(bus.deq_valid), 32'd0);
    tick();
    check("t3_valid", 32'(bus.deq_valid), 32'd1);
    check("t3_deq_pc", bus.deq_pc, 32'd24);
    check("t3_deq_inst", bus.deq_inst, word_at(32'd24));

    // Redirect to the last word: one entry then END.
    issue_redirect(32'd1020);
    tick();
    check("t4_imem_pc", bus.imem_pc, 32'd1020);
    check("t4_occ0", 32'(bus.occupancy), 32'd0);
    tick();
    check("t4_valid", 32'(bus.deq_valid), 32'd1);
    check("t4_deq_pc", bus.deq_pc, 32'd1020);
    check("t4_pc_end", bus.imem_pc, 32'd1024);
    check("t4_not_halted", 32'(bus.halted), 32'd0);
    tick();
    check("t4_occ1", 32'(bus.occupancy), 32'd1);
    check("t4_pc_hold", bus.imem_pc, 32'd1024);
    bus.deq_ready = 1'b1;
    tick();
    check("t4_halted", 32'(bus.halted), 32'd1);
    check("t4_valid0", 32'(bus.deq_valid), 32'd0);
    tick();
    check("t4_halted2", 32'(bus.halted), 32'd1);
    check("t4_pc_hold2", bus.imem_pc, 32'd1024);

    // Redirect beyond memory halts at once; redirect to 0 resumes.
    bus.deq_ready = 1'b0;
    issue_redirect(32'd2048);
    tick();
    check("t5_occ", 32'(bus.occupancy), 32'd0);
    check("t5_halted", 32'(bus.halted), 32'd1);
    check("t5_valid", 32'(bus.deq_valid), 32'd0);
    check("t5_imem_pc", bus.imem_pc, 32'd2048);
    tick();
    check("t5_valid2", 32'(bus.deq_valid), 32'd0);
    issue_redirect(32'd0);
    tick();
    check("t5_resume_pc", bus.imem_pc, 32'd0);
    check("t5_resume_halted", 32'(bus.halted), 32'd0);
    tick();
    check("t5_resume_valid", 32'(bus.deq_valid), 32'd1);
    check("t5_resume_deq_pc", bus.deq_pc, 32'd0);

    // Reset beats a simultaneous redirect and pop.
    repeat (2) tick();
    check("t6_pre_occ", 32'(bus.occupancy), 32'd3);
    bus.deq_ready = 1'b1;
    issue_redirect(32'd500);
    issue_reset();
    tick();
    check("t6_pc", bus.imem_pc, RESET_PC);
    check("t6_occ", 32'(bus.occupancy), 32'd0);
    check("t6_valid", 32'(bus.deq_valid), 32'd0);
    check("t6_halted", 32'(bus.halted), 32'd0);

    // Random traffic: ready throttling, redirects of all kinds, occasional reset.
    for (int c = 0; c < 2500; c++) begin
      bus.deq_ready = ($urandom_range(0, 99) < 70);
      r = $urandom_range(0, 999);
      if (r < 4) begin
        issue_reset();
      end else if (r < 40) begin
        case ($urandom_range(0, 3))
          0:       t = 32'($urandom_range(0, 1023));
          1:       t = 32'($urandom_range(990, 1030));
          2:       t = 32'($urandom_range(1024, 8191));
          default: t = $urandom;
        endcase
        issue_redirect(t);
      end
      tick();
    end
    bus.deq_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
